// File: rtl/bit_reg_reader.sv
// Snapshots a bank of one-bit register outputs on start and shifts them out,
// one bit per accepted valid/ready transfer, from a private copy of the bank.
module bit_reg_reader #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] reg_bits,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_snap;
    logic [CW-1:0] r_cnt;

    logic [N-1:0]  w_ordered;
    logic          w_xfer;

    // Reorder the snapshot once so the counter always indexes the next bit out.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign w_ordered[gi] = r_snap[N-1-gi];
            end else begin : g_lsb
                assign w_ordered[gi] = r_snap[gi];
            end
        end
    endgenerate

    assign w_xfer = ser_valid & ser_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_snap  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap  <= reg_bits;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_xfer) begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign ser_valid = (r_state == ST_SHIFT);
    assign busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign done      = (r_state == ST_DONE);
    assign ser_out   = ser_valid & w_ordered[r_cnt];

endmodule

// File: tb/tb_bit_reg_reader.sv
// Bench for bit_reg_reader: 8-bit MSB-first instance with a bit scoreboard,
// plus a 1-bit LSB-first instance for the single-bit case.
module tb_bit_reg_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] reg_bits;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_ready;
    logic       busy;
    logic       done;

    logic       s1_start;
    logic [0:0] s1_reg_bits;
    logic       s1_ser_out;
    logic       s1_ser_valid;
    logic       s1_ser_ready;
    logic       s1_busy;
    logic       s1_done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic exp_q[$];

    always #5 clk = ~clk;

    bit_reg_reader #(.N(8), .MSB_FIRST(1'b1)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .reg_bits  (reg_bits),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .busy      (busy),
        .done      (done)
    );

    bit_reg_reader #(.N(1), .MSB_FIRST(1'b0)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s1_start),
        .reg_bits  (s1_reg_bits),
        .ser_out   (s1_ser_out),
        .ser_valid (s1_ser_valid),
        .ser_ready (s1_ser_ready),
        .busy      (s1_busy),
        .done      (s1_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    task automatic start_txn(input logic [7:0] v);
        push_bits(v);
        reg_bits = v;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("[TB] start txn reg_bits=%02h", v);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    // Scoreboard: every accepted bit is compared against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ser_valid && ser_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_bit", 32'd1, 32'd0);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    check("sb_bit", 32'(ser_out), 32'(e));
                end
            end
            if (!ser_valid) check("out_zero_idle", 32'(ser_out), 32'd0);
            if (done) n_done++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst_n        = 1'b0;
        start        = 1'b0;
        reg_bits     = 8'h00;
        ser_ready    = 1'b1;
        s1_start     = 1'b0;
        s1_reg_bits  = 1'b0;
        s1_ser_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(ser_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_out",   32'(ser_out),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic MSB-first stream and cycle-accurate framing.
        start_txn(8'b1011_0010);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("s1_valid", 32'(ser_valid), 32'(i <= 8));
            check("s1_done",  32'(done),      32'(i == 9));
            check("s1_busy",  32'(busy),      32'(i <= 9));
        end
        check("s1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: stall for 3 cycles after the third bit.
        @(posedge clk);
        #1;
        start_txn(8'b1011_0010);
        repeat (3) @(posedge clk);
        #1;
        ser_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("s2_stall_valid", 32'(ser_valid), 32'd1);
            check("s2_stall_out",   32'(ser_out),   32'd1);
        end
        @(posedge clk);
        #1;
        ser_ready = 1'b1;
        wait_done();
        check("s2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: bank changes after the snapshot edge.
        @(posedge clk);
        #1;
        start_txn(8'hA5);
        reg_bits = 8'h00;
        wait_done();
        check("s3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: start while busy and during DONE is ignored.
        @(posedge clk);
        #1;
        d0 = n_done;
        start_txn(8'h3C);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s4_idle_busy",  32'(busy),      32'd0);
            check("s4_idle_valid", 32'(ser_valid), 32'd0);
        end
        check("s4_done_count", 32'(n_done - d0), 32'd1);
        check("s4_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: asynchronous reset in the middle of bit 5.
        @(posedge clk);
        #1;
        start_txn(8'h5A);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("s5_rst_valid", 32'(ser_valid), 32'd0);
        check("s5_rst_busy",  32'(busy),      32'd0);
        check("s5_rst_done",  32'(done),      32'd0);
        check("s5_rst_out",   32'(ser_out),   32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("s5_post_valid", 32'(ser_valid), 32'd0);
        @(posedge clk);
        #1;
        start_txn(8'hFF);
        wait_done();
        check("s5_q_empty", 32'(exp_q.size()), 32'd0);

        // 6: single-bit instance, LSB-first.
        @(posedge clk);
        #1;
        s1_reg_bits = 1'b1;
        s1_start    = 1'b1;
        @(posedge clk);
        #1;
        s1_start = 1'b0;
        @(negedge clk);
        check("n1_valid", 32'(s1_ser_valid), 32'd1);
        check("n1_out",   32'(s1_ser_out),   32'd1);
        check("n1_done0", 32'(s1_done),      32'd0);
        @(negedge clk);
        check("n1_done",  32'(s1_done),      32'd1);
        check("n1_dvalid", 32'(s1_ser_valid), 32'd0);
        @(negedge clk);
        check("n1_idle",  32'(s1_busy),      32'd0);
        $display("[TB] N=1 transaction checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
